// File: rtl/atanh_approx_4bit_seq.sv
// Sequential 4-bit atanh approximation: a linear search over a forward tanh table.
// Optional macro ATANH_SAT_EN makes y=15 saturate to Out1=15 without searching.
module atanh_approx_4bit_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] In,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] Out1,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_y;
  logic [3:0] r_cnt;
  logic [3:0] r_out;
  logic       r_sat;
  logic       r_in_ready;
  logic       r_out_valid;
  logic       r_busy;
  logic       w_accept;
  logic       w_match;
  logic       w_sat_in;

  // Forward table T[x] = round(15*tanh(x/4))
  function automatic logic [3:0] fwd_tab(input logic [3:0] x);
    logic [3:0] t;
    case (x)
      4'd0:    t = 4'd0;
      4'd1:    t = 4'd4;
      4'd2:    t = 4'd7;
      4'd3:    t = 4'd10;
      4'd4:    t = 4'd11;
      4'd5:    t = 4'd13;
      4'd6:    t = 4'd14;
      4'd7:    t = 4'd14;
      4'd8:    t = 4'd14;
      default: t = 4'd15;
    endcase
    return t;
  endfunction

  assign w_accept = (r_state == S_IDLE) && r_in_ready && in_valid;
  assign w_match  = (fwd_tab(r_cnt) >= r_y);

`ifdef ATANH_SAT_EN
  assign w_sat_in = (In == 4'd15);
`else
  assign w_sat_in = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a saturating request spends two edges in SEARCH so DONE lands at +2
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SEARCH;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEARCH: begin
        if (r_sat) begin
          if (r_cnt == 4'd1) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_SEARCH;
          end
        end else if (w_match) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_SEARCH;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered status flags (flags follow the next state)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y         <= 4'd0;
      r_cnt       <= 4'd0;
      r_out       <= 4'd0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_SEARCH);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_y   <= In;
            r_cnt <= 4'd0;
            r_sat <= w_sat_in;
            if (w_sat_in) begin
              r_out <= 4'd15;
            end
          end
        end
        S_SEARCH: begin
          // T[9]=15 always matches, so r_cnt stops at 9 in a normal search
          if (r_sat) begin
            r_cnt <= r_cnt + 4'd1;
          end else if (w_match) begin
            r_out <= r_cnt;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_out <= r_out;
        end
        default: begin
          r_cnt <= 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign Out1      = r_out;

endmodule

// File: tb/tb_atanh_approx_4bit_seq.sv
// Bench for atanh_approx_4bit_seq: vector table sweep plus handshake, disturbance and reset sequences.
module tb_atanh_approx_4bit_seq;

  typedef struct {
    logic [3:0] y;
    logic [3:0] x;
    int         lat;
  } vec_t;

  typedef struct {
    logic [3:0] x;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] In;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] Out1;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  exp_t sb_q[$];
  vec_t vecs[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  atanh_approx_4bit_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .In        (In),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Out1      (Out1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One transaction; hold = cycles to keep out_ready low in DONE; disturb = poke In/in_valid mid-search
  task automatic do_txn(input logic [3:0] y, input logic [3:0] ex, input int elat,
                        input int hold, input bit disturb);
    exp_t e;
    exp_t got;
    int   lat;
    check("in_ready_before_issue", in_ready, 1);
    In        = y;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    e.x   = ex;
    e.lat = elat;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      check("busy_in_search", busy, 1);
      check("in_ready_in_search", in_ready, 0);
      if (disturb && lat == 1) begin
        In       = 4'd0;
        in_valid = 1'b1;
      end
      if (disturb && lat == 2) begin
        In       = 4'd5;
        in_valid = 1'b0;
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!out_valid) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout y=%0d: no out_valid after %0d edges, expected %0d", y, lat, elat);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty y=%0d: got output with nothing expected", y);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("Out1_y%0d", y), Out1, got.x);
      check($sformatf("latency_y%0d", y), lat, got.lat);
      check("busy_in_done", busy, 0);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk);
        @(negedge clk);
        check("hold_out_valid", out_valid, 1);
        check("hold_Out1", Out1, got.x);
        check("hold_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_in_ready", in_ready, 1);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  initial begin
    logic [3:0] exp_x [16];
    logic [3:0] y_rst;
    exp_x = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2,
              4'd3, 4'd3, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd9};
    for (int i = 0; i < 16; i++) begin
      vecs[i].y   = 4'(i);
      vecs[i].x   = exp_x[i];
      vecs[i].lat = int'(exp_x[i]) + 1;
    end
`ifdef ATANH_SAT_EN
    vecs[15].x   = 4'd15;
    vecs[15].lat = 2;
    y_rst        = 4'd14;
`else
    y_rst        = 4'd15;
`endif

    rst_n     = 1'b0;
    In        = 4'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_Out1", Out1, 0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_first_edge", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_first_edge", in_ready, 1);

    // Zero input: result at +1 edge, ready again two edges after acceptance
    do_txn(4'd0, 4'd0, 1, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      do_txn(vecs[i].y, vecs[i].x, vecs[i].lat, 0, 1'b0);
    end

    do_txn(4'd7, 4'd2, 3, 5, 1'b0);

    do_txn(4'd10, 4'd3, 4, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("no_second_txn_valid", out_valid, 0);
      check("no_second_txn_busy", busy, 0);
    end

    // Reset in the middle of a long search
    In        = y_rst;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sb_q.push_back('{x: 4'd9, lat: 10});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    sb_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_Out1", Out1, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("no_stale_result", out_valid, 0);
    end

    do_txn(4'd12, 4'd5, 6, 0, 1'b0);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/atanh_approx_4bit_seq.md
ATANH_APPROX_4BIT_SEQ -- requirements
Module: atanh_approx_4bit_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock, all state on rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port In, input, 4 bits: unsigned tanh-domain code y (y/15 approximates tanh value, 0..1).
REQ-004 The block SHALL have the port in_valid, input, 1 bit: In is valid.
REQ-005 The block SHALL have the port in_ready, output, 1 bit: block can accept In.
REQ-006 The block SHALL have the port Out1, output, 4 bits: unsigned inverse code x (x/4 approximates atanh, 0..3.75).
REQ-007 The block SHALL have the port out_valid, output, 1 bit: Out1 holds a result.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: consumer accepts Out1.
REQ-009 The block SHALL have the port busy, output, 1 bit: high in SEARCH state.

Function
REQ-010 The block SHALL contain a fixed 16-entry forward table T[x] = round(15*tanh(x/4)) = {0,4,7,10,11,13,14,14,14,15,15,15,15,15,15,15} for x = 0..15.
REQ-011 The result SHALL be the smallest x with T[x] >= y: y=0 gives 0; y=1..4 gives 1; y=5..7 gives 2; y=8..10 gives 3; y=11 gives 4; y=12..13 gives 5; y=14 gives 6; y=15 gives 9 (macro absent).
REQ-012 The block SHALL implement a three-state FSM: IDLE, SEARCH, DONE.
REQ-013 In IDLE, in_ready SHALL be 1; an edge with in_valid=1 SHALL capture In into a 4-bit register y_r, clear candidate counter cnt to 0, and enter SEARCH.
REQ-014 In SEARCH, each cycle SHALL compare T[cnt] >= y_r; on a match the block SHALL load Out1 = cnt and enter DONE; otherwise it SHALL increment cnt by 1.
REQ-015 cnt SHALL never exceed 9; no wrap-around path SHALL exist, because T[9] = 15 >= every y.
REQ-016 Latency SHALL be out_valid high exactly x+1 rising edges after the accepting edge; y=0 gives 1 edge; y=15 gives 10 edges.
REQ-017 In DONE, out_valid SHALL be 1 and Out1 SHALL be held stable until an edge with out_ready=1, after which the FSM SHALL return to IDLE.
REQ-018 in_ready SHALL be 0 in SEARCH and DONE; in_valid SHALL be ignored there, and In changes SHALL not affect an in-flight search.
REQ-019 No input-to-output bypass SHALL exist; the minimum issue interval SHALL be x+3 cycles (accept, search, DONE handshake, IDLE).
REQ-020 out_ready asserted outside DONE SHALL have no effect.
REQ-021 busy SHALL equal 1 exactly when the state is SEARCH.

Reset
REQ-022 On rst_n=0 the FSM SHALL go to IDLE asynchronously, and y_r, cnt, and Out1 SHALL be set to 0.
REQ-023 During reset, out_valid=0, busy=0, and in_ready=0 SHALL hold; in_ready SHALL become 1 on the first clk edge after rst_n rises.
REQ-024 Reset asserted in SEARCH or DONE SHALL discard the pending result with no output handshake.

Configuration
REQ-025 When macro ATANH_SAT_EN is defined, y=15 SHALL bypass the search: the accepting edge SHALL load Out1=15 and the next edge SHALL enter DONE (latency 2), representing the atanh(1) saturation.
REQ-026 When ATANH_SAT_EN is undefined, y=15 SHALL follow the normal search and produce Out1=9 at latency 10.
REQ-027 When ATANH_SAT_EN is defined, all y < 15 SHALL behave identically to the undefined case.

Verification
REQ-028 The bench SHALL drive In=0, in_valid=1 with out_ready=1 and require out_valid at +1 edge with Out1=0, then in_ready=1 two edges after acceptance.
REQ-029 The bench SHALL sweep y=0..15 exhaustively and require Out1 to match REQ-011 with latency equal to Out1+1 (macro absent).
REQ-030 The bench SHALL hold out_ready=0 for 5 cycles with y=7 and require out_valid=1 with Out1=2 stable throughout and in_ready=0, then release and require IDLE.
REQ-031 The bench SHALL change In and pulse in_valid during SEARCH for y=10, and require result 3 unaffected and no second transaction.
REQ-032 The bench SHALL assert rst_n=0 at cycle 4 of a y=15 search, and require immediate out_valid=0, busy=0, Out1=0 and no stale result after release.
REQ-033 With ATANH_SAT_EN defined, the bench SHALL apply y=15 and require Out1=15 with out_valid at +2 edges, and y=14 to give 6 at +7 edges.
